// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the single-port memory arbiter.
// The optional statistics block is enabled with MEM_ARBITER_STATS_EN.
package mem_arbiter_pkg;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t S_IDLE   = 2'd0;
  localparam arb_state_t S_ACCESS = 2'd1;
  localparam arb_state_t S_WAIT   = 2'd2;
  localparam arb_state_t S_RESP   = 2'd3;

  typedef enum logic {REQ_I = 1'b0, REQ_D = 1'b1} req_id_t;

  localparam int MAX_READ_LAT = 7;
  localparam int LAT_CNT_W    = $clog2(MAX_READ_LAT + 1);

endpackage

// File: rtl/mem_arbiter_stats.sv
// Saturating 32-bit grant and conflict counters for the memory arbiter.
// Instantiated only when MEM_ARBITER_STATS_EN is defined.
module mem_arbiter_stats (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_inc_i,
  input  logic        i_inc_d,
  input  logic        i_inc_conf,
  output logic [31:0] o_i_grants,
  output logic [31:0] o_d_grants,
  output logic [31:0] o_conflicts
);

  logic [31:0] r_i_grants;
  logic [31:0] r_d_grants;
  logic [31:0] r_conflicts;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_i_grants  <= '0;
      r_d_grants  <= '0;
      r_conflicts <= '0;
    end else begin
      if (i_inc_i && (r_i_grants != '1))
        r_i_grants <= r_i_grants + 32'd1;
      if (i_inc_d && (r_d_grants != '1))
        r_d_grants <= r_d_grants + 32'd1;
      if (i_inc_conf && (r_conflicts != '1))
        r_conflicts <= r_conflicts + 32'd1;
    end
  end

  assign o_i_grants  = r_i_grants;
  assign o_d_grants  = r_d_grants;
  assign o_conflicts = r_conflicts;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between fetch (i_*) and load/store (d_*).
// Define MEM_ARBITER_STATS_EN to add the stat_* counter outputs.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 64,
  parameter int READ_LAT = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_valid,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_valid,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy,
  output logic [1:0]          dbg_state
`ifdef MEM_ARBITER_STATS_EN
  ,
  output logic [31:0]         stat_i_grants,
  output logic [31:0]         stat_d_grants,
  output logic [31:0]         stat_conflicts
`endif
);

  // Handshake: a requester holds req high until its valid pulses for one cycle
  // in RESP; inputs are only sampled in IDLE, so nothing can cancel an access.
  arb_state_t          r_state;
  req_id_t             r_last_grant;
  req_id_t             r_owner;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W/8-1:0] r_wstrb;
  logic [LAT_CNT_W-1:0] r_lat_cnt;
  logic [DATA_W-1:0]   r_i_rdata;
  logic [DATA_W-1:0]   r_d_rdata;

  logic    w_any_req;
  logic    w_pick_d;
  logic    w_store;
  req_id_t w_winner;

  // On a tie the requester that did not win last time goes first.
  assign w_any_req = i_req | d_req;
  assign w_pick_d  = d_req & (~i_req | (r_last_grant == REQ_I));
  assign w_store   = w_pick_d & d_we;
  assign w_winner  = w_pick_d ? REQ_D : REQ_I;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_last_grant <= REQ_D;
      r_owner      <= REQ_I;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_lat_cnt    <= '0;
      r_i_rdata    <= '0;
      r_d_rdata    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_state      <= S_ACCESS;
            r_owner      <= w_winner;
            r_last_grant <= w_winner;
            r_addr       <= w_pick_d ? d_addr : i_addr;
            r_we         <= w_store;
            r_wdata      <= w_store ? d_wdata : '0;
            r_wstrb      <= w_store ? d_wstrb : '0;
          end
        end
        S_ACCESS: begin
          if (r_we) begin
            r_state   <= S_RESP;
            r_d_rdata <= '0;
          end else begin
            r_state   <= S_WAIT;
            r_lat_cnt <= LAT_CNT_W'(READ_LAT - 1);
          end
        end
        S_WAIT: begin
          if (r_lat_cnt == '0) begin
            r_state <= S_RESP;
            if (r_owner == REQ_D)
              r_d_rdata <= mem_rdata;
            else
              r_i_rdata <= mem_rdata;
          end else begin
            r_lat_cnt <= r_lat_cnt - LAT_CNT_W'(1);
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_en    = (r_state == S_ACCESS);
  assign mem_we    = mem_en & r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_wstrb = r_wstrb;

  assign i_valid   = (r_state == S_RESP) && (r_owner == REQ_I);
  assign d_valid   = (r_state == S_RESP) && (r_owner == REQ_D);
  assign i_rdata   = r_i_rdata;
  assign d_rdata   = r_d_rdata;
  assign busy      = (r_state != S_IDLE);
  assign dbg_state = r_state;

`ifdef MEM_ARBITER_STATS_EN
  logic w_grant_i;
  logic w_grant_d;
  logic w_conflict;

  // While busy, the requester not owning the access is the one left waiting.
  assign w_grant_i  = (r_state == S_IDLE) & w_any_req & ~w_pick_d;
  assign w_grant_d  = (r_state == S_IDLE) & w_pick_d;
  assign w_conflict = (r_state == S_IDLE) ? (i_req & d_req)
                    : ((r_owner == REQ_I) ? d_req : i_req);

  mem_arbiter_stats u_stats (
    .clk         (clk),
    .reset       (reset),
    .i_inc_i     (w_grant_i),
    .i_inc_d     (w_grant_d),
    .i_inc_conf  (w_conflict),
    .o_i_grants  (stat_i_grants),
    .o_d_grants  (stat_d_grants),
    .o_conflicts (stat_conflicts)
  );
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter: default READ_LAT=1 instance plus a READ_LAT=4 instance.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mem_arbiter;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam logic [DW-1:0] JUNK = 64'hBAD0_BAD0_BAD0_BAD0;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  logic [AW-1:0] exp_q[$];

  // READ_LAT = 1 instance
  logic          i_req, i_valid, d_req, d_we, d_valid;
  logic          mem_en, mem_we, busy;
  logic [AW-1:0] i_addr, d_addr, mem_addr;
  logic [DW-1:0] i_rdata, d_rdata, d_wdata, mem_wdata, mem_rdata;
  logic [7:0]    d_wstrb, mem_wstrb;
  logic [1:0]    dbg_state;

  // READ_LAT = 4 instance
  logic          i_req4, i_valid4, d_req4, d_we4, d_valid4;
  logic          mem_en4, mem_we4, busy4;
  logic [AW-1:0] i_addr4, d_addr4, mem_addr4;
  logic [DW-1:0] i_rdata4, d_rdata4, d_wdata4, mem_wdata4, mem_rdata4;
  logic [7:0]    d_wstrb4, mem_wstrb4;
  logic [1:0]    dbg_state4;

`ifdef MEM_ARBITER_STATS_EN
  logic [31:0] st_i, st_d, st_c, st_i4, st_d4, st_c4;
`endif

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(1)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wstrb(d_wstrb), .d_rdata(d_rdata), .d_valid(d_valid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .busy(busy), .dbg_state(dbg_state)
`ifdef MEM_ARBITER_STATS_EN
    , .stat_i_grants(st_i), .stat_d_grants(st_d), .stat_conflicts(st_c)
`endif
  );

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(4)) dut4 (
    .clk(clk), .reset(reset),
    .i_req(i_req4), .i_addr(i_addr4), .i_rdata(i_rdata4), .i_valid(i_valid4),
    .d_req(d_req4), .d_we(d_we4), .d_addr(d_addr4), .d_wdata(d_wdata4),
    .d_wstrb(d_wstrb4), .d_rdata(d_rdata4), .d_valid(d_valid4),
    .mem_en(mem_en4), .mem_we(mem_we4), .mem_addr(mem_addr4),
    .mem_wdata(mem_wdata4), .mem_wstrb(mem_wstrb4), .mem_rdata(mem_rdata4),
    .busy(busy4), .dbg_state(dbg_state4)
`ifdef MEM_ARBITER_STATS_EN
    , .stat_i_grants(st_i4), .stat_d_grants(st_d4), .stat_conflicts(st_c4)
`endif
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    total++;
    if (busy !== 1'b0 || mem_en !== 1'b0 || mem_we !== 1'b0 || dbg_state !== 2'd0) begin
      bad++;
      $display("FAIL reset_ctrl busy=%b mem_en=%b mem_we=%b state=%0d, want 0 0 0 0",
               busy, mem_en, mem_we, dbg_state);
    end
    total++;
    if (mem_addr !== '0 || mem_wdata !== '0 || mem_wstrb !== '0) begin
      bad++;
      $display("FAIL reset_mem addr=%0h wdata=%0h wstrb=%0h, want 0 0 0", mem_addr, mem_wdata, mem_wstrb);
    end
    total++;
    if (i_valid !== 1'b0 || d_valid !== 1'b0 || i_rdata !== '0 || d_rdata !== '0 || busy4 !== 1'b0) begin
      bad++;
      $display("FAIL reset_resp iv=%b dv=%b ird=%0h drd=%0h busy4=%b, want all 0",
               i_valid, d_valid, i_rdata, d_rdata, busy4);
    end

    // Reset arriving while a fetch is in WAIT
    reset = 1'b1;
    i_req = 1'b1;
    i_addr = 64'h100;
    tick();
    total++;
    if (mem_en !== 1'b1 || mem_addr !== 64'h100) begin
      bad++;
      $display("FAIL rstwait_access mem_en=%b addr=%0h, want 1 100", mem_en, mem_addr);
    end
    tick();
    total++;
    if (dbg_state !== 2'd2 || busy !== 1'b1) begin
      bad++;
      $display("FAIL rstwait_wait state=%0d busy=%b, want 2 1", dbg_state, busy);
    end
    reset = 1'b0;
    i_req = 1'b0;
    mem_rdata = 64'h77;
    tick();
    total++;
    if (i_valid !== 1'b0 || busy !== 1'b0 || mem_en !== 1'b0 || dbg_state !== 2'd0) begin
      bad++;
      $display("FAIL rstwait_after iv=%b busy=%b mem_en=%b state=%0d, want 0 0 0 0",
               i_valid, busy, mem_en, dbg_state);
    end
    reset = 1'b1;
    mem_rdata = JUNK;
    tick();
    total++;
    if (i_valid !== 1'b0 || i_rdata !== '0) begin
      bad++;
      $display("FAIL rstwait_drop iv=%b ird=%0h, want 0 0", i_valid, i_rdata);
    end
  endtask

  task automatic test_fetch();
    i_req = 1'b1;
    i_addr = 64'h40;
    mem_rdata = JUNK;
    total++;
    if (mem_en !== 1'b0) begin
      bad++;
      $display("FAIL fetch_en_t0 mem_en=%b, want 0", mem_en);
    end
    tick();
    total++;
    if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 64'h40 || mem_wstrb !== 8'h00) begin
      bad++;
      $display("FAIL fetch_access en=%b we=%b addr=%0h wstrb=%0h, want 1 0 40 0",
               mem_en, mem_we, mem_addr, mem_wstrb);
    end
    tick();
    total++;
    if (mem_en !== 1'b0 || i_valid !== 1'b0) begin
      bad++;
      $display("FAIL fetch_wait en=%b iv=%b, want 0 0", mem_en, i_valid);
    end
    mem_rdata = 64'h00A00093;
    tick();
    mem_rdata = JUNK;
    total++;
    if (i_valid !== 1'b1 || i_rdata !== 64'h00A00093 || d_valid !== 1'b0) begin
      bad++;
      $display("FAIL fetch_resp iv=%b ird=%0h dv=%b, want 1 a00093 0", i_valid, i_rdata, d_valid);
    end
    i_req = 1'b0;
    tick();
    total++;
    if (i_valid !== 1'b0 || i_rdata !== 64'h00A00093 || busy !== 1'b0) begin
      bad++;
      $display("FAIL fetch_hold iv=%b ird=%0h busy=%b, want 0 a00093 0", i_valid, i_rdata, busy);
    end
  endtask

  task automatic test_tie();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    i_req = 1'b1;
    d_req = 1'b1;
    d_we = 1'b0;
    i_addr = 64'h80;
    d_addr = 64'h90;
    tick();
    total++;
    if (mem_en !== 1'b1 || mem_addr !== 64'h80) begin
      bad++;
      $display("FAIL tie_first_addr en=%b addr=%0h, want 1 80", mem_en, mem_addr);
    end
    tick();
    mem_rdata = 64'h1111;
    tick();
    mem_rdata = JUNK;
    total++;
    if (i_valid !== 1'b1 || d_valid !== 1'b0 || i_rdata !== 64'h1111) begin
      bad++;
      $display("FAIL tie_i_resp iv=%b dv=%b ird=%0h, want 1 0 1111", i_valid, d_valid, i_rdata);
    end
    i_req = 1'b0;
    tick();
    total++;
    if (busy !== 1'b0 || mem_en !== 1'b0) begin
      bad++;
      $display("FAIL tie_gap busy=%b en=%b, want 0 0", busy, mem_en);
    end
    tick();
    total++;
    if (mem_en !== 1'b1 || mem_addr !== 64'h90 || mem_we !== 1'b0) begin
      bad++;
      $display("FAIL tie_second_addr en=%b addr=%0h we=%b, want 1 90 0", mem_en, mem_addr, mem_we);
    end
    tick();
    mem_rdata = 64'h2222;
    tick();
    mem_rdata = JUNK;
    total++;
    if (d_valid !== 1'b1 || i_valid !== 1'b0 || d_rdata !== 64'h2222 || i_rdata !== 64'h1111) begin
      bad++;
      $display("FAIL tie_d_resp dv=%b iv=%b drd=%0h ird=%0h, want 1 0 2222 1111",
               d_valid, i_valid, d_rdata, i_rdata);
    end
    d_req = 1'b0;
    tick();
  endtask

  task automatic test_store();
    d_req = 1'b1;
    d_we = 1'b1;
    d_addr = 64'h200;
    d_wdata = 64'hDEADBEEF;
    d_wstrb = 8'h0F;
    tick();
    total++;
    if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 64'h200 ||
        mem_wdata !== 64'hDEADBEEF || mem_wstrb !== 8'h0F) begin
      bad++;
      $display("FAIL store_access en=%b we=%b addr=%0h wdata=%0h wstrb=%0h, want 1 1 200 deadbeef f",
               mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb);
    end
    tick();
    total++;
    if (d_valid !== 1'b1 || d_rdata !== '0 || i_valid !== 1'b0 || mem_en !== 1'b0) begin
      bad++;
      $display("FAIL store_resp dv=%b drd=%0h iv=%b en=%b, want 1 0 0 0", d_valid, d_rdata, i_valid, mem_en);
    end
    d_req = 1'b0;
    d_we = 1'b0;
    tick();
    total++;
    if (d_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL store_done dv=%b busy=%b, want 0 0", d_valid, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_rd;
    logic          is_d;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    i_req = 1'b1;
    d_req = 1'b1;
    d_we = 1'b0;
    i_addr = 64'h1000;
    d_addr = 64'h2000;
    exp_q.push_back(64'h1000);
    exp_q.push_back(64'h2000);
    exp_q.push_back(64'h1000);
    exp_q.push_back(64'h2000);
    for (int k = 0; k < 4; k++) begin
      exp_addr = exp_q.pop_front();
      is_d = (exp_addr == 64'h2000);
      exp_rd = 64'hC0DE_0000 + 64'(k);
      total++;
      if (busy !== 1'b0) begin
        bad++;
        $display("FAIL b2b_idle k=%0d busy=%b, want 0", k, busy);
      end
      tick();
      total++;
      if (mem_en !== 1'b1 || mem_addr !== exp_addr) begin
        bad++;
        $display("FAIL b2b_grant k=%0d en=%b addr=%0h, want 1 %0h", k, mem_en, mem_addr, exp_addr);
      end
      tick();
      mem_rdata = exp_rd;
      tick();
      mem_rdata = JUNK;
      total++;
      if (i_valid !== !is_d || d_valid !== is_d) begin
        bad++;
        $display("FAIL b2b_valid k=%0d iv=%b dv=%b, want %b %b", k, i_valid, d_valid, !is_d, is_d);
      end
      total++;
      if ((is_d ? d_rdata : i_rdata) !== exp_rd) begin
        bad++;
        $display("FAIL b2b_rdata k=%0d got=%0h, want %0h", k, is_d ? d_rdata : i_rdata, exp_rd);
      end
      tick();
    end
    i_req = 1'b0;
    d_req = 1'b0;
    tick();
    total++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL b2b_end busy=%b left=%0d, want 0 0", busy, exp_q.size());
    end
  endtask

  task automatic test_lat4();
    mem_rdata4 = JUNK;
    d_req4 = 1'b1;
    d_we4 = 1'b0;
    d_addr4 = 64'h300;
    tick();
    total++;
    if (mem_en4 !== 1'b1 || mem_addr4 !== 64'h300 || mem_we4 !== 1'b0) begin
      bad++;
      $display("FAIL lat4_access en=%b addr=%0h we=%b, want 1 300 0", mem_en4, mem_addr4, mem_we4);
    end
    tick();
    d_addr4 = 64'h999;
    tick();
    tick();
    total++;
    if (busy4 !== 1'b1 || d_valid4 !== 1'b0 || mem_en4 !== 1'b0) begin
      bad++;
      $display("FAIL lat4_waiting busy=%b dv=%b en=%b, want 1 0 0", busy4, d_valid4, mem_en4);
    end
    tick();
    mem_rdata4 = 64'h1234;
    total++;
    if (d_valid4 !== 1'b0) begin
      bad++;
      $display("FAIL lat4_early dv=%b, want 0", d_valid4);
    end
    tick();
    mem_rdata4 = JUNK;
    total++;
    if (d_valid4 !== 1'b1 || d_rdata4 !== 64'h1234 || mem_addr4 !== 64'h300) begin
      bad++;
      $display("FAIL lat4_resp dv=%b drd=%0h addr=%0h, want 1 1234 300", d_valid4, d_rdata4, mem_addr4);
    end
    d_req4 = 1'b0;
    tick();
    total++;
    if (d_valid4 !== 1'b0 || busy4 !== 1'b0) begin
      bad++;
      $display("FAIL lat4_done dv=%b busy=%b, want 0 0", d_valid4, busy4);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b0;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    mem_rdata = JUNK;
    i_req4 = 1'b0; i_addr4 = '0;
    d_req4 = 1'b0; d_we4 = 1'b0; d_addr4 = '0; d_wdata4 = '0; d_wstrb4 = '0;
    mem_rdata4 = JUNK;
    tick();
    test_reset();
    test_fetch();
    test_tie();
    test_store();
    test_back_to_back();
    test_lat4();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port memory between the instruction-fetch requester (i_*) and the load/store requester (d_*) of the multicycle core.
- Sits between the processing datapath and the unified memory model; replaces the separate instruction and data memory instances.
- Owns all memory-side timing: request latching, round-robin grant on conflict, fixed read-latency wait and a registered response.

Parameters:
- ADDR_W, 64, address width of requesters and memory port.
- DATA_W, 64, data width; DATA_W/8 byte strobes.
- READ_LAT, 1, cycles from the mem_en cycle until mem_rdata is valid; legal range 1..7.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-low reset.
- i_req  in  1  instruction read request; level, held until i_valid.
- i_addr  in  ADDR_W  fetch address.
- i_rdata  out  DATA_W  fetched word, meaningful while i_valid.
- i_valid  out  1  one-cycle response pulse.
- d_req  in  1  data request; level, held until d_valid.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_wstrb  in  DATA_W/8  store byte enables, already spliced by the requester.
- d_rdata  out  DATA_W  load data, meaningful while d_valid.
- d_valid  out  1  one-cycle response pulse; also pulses for stores.
- mem_en, mem_we  out  1  memory access strobe and write enable.
- mem_addr, mem_wdata  out  ADDR_W, DATA_W  registered address and write data.
- mem_wstrb  out  DATA_W/8  registered byte strobes; all zero for reads.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (reset==0 at posedge, any state):
  - State goes to IDLE; any in-flight transaction is dropped with no valid pulse.
  - All outputs are 0.
  - last_grant = D, so an instruction request wins the first tie.
- States: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - If any req is high, latch the winner's addr, we, wdata and wstrb (reads force we=0 and wstrb=0), then go to ACCESS.
  - Tie: the requester that is not last_grant wins, and last_grant is updated to the winner.
  - A single request always wins regardless of last_grant.
- ACCESS:
  - Exactly one cycle with mem_en=1 and the latched mem_* values.
  - Read goes to WAIT with lat_cnt=READ_LAT-1; write goes to RESP.
- WAIT:
  - Lasts READ_LAT cycles; lat_cnt decrements each cycle.
  - When lat_cnt==0, capture mem_rdata into the response register and go to RESP.
- RESP:
  - Asserts exactly one cycle of the winner's valid; the winner's rdata holds the captured word (0 for stores).
  - Returns to IDLE.
- Latency from req sampled in cycle T:
  - Read: valid in T+2+READ_LAT, i.e. T+3 at the default.
  - Write: valid in T+2.
- Request rules:
  - Requester inputs are ignored outside IDLE; changes mid-flight have no effect.
  - Dropping req mid-flight does not cancel the access; valid still pulses.
  - A req still high in the cycle after valid counts as a new request.
- The losing requester waits with req high and is served next; it is granted in the IDLE cycle that follows RESP.
- rdata outputs hold their last value between pulses; only valid qualifies them.
- No address range or alignment checking.

Optional Feature:
- Macro: MEM_ARBITER_STATS_EN.
- Enabled:
  - Adds outputs stat_i_grants, stat_d_grants and stat_conflicts, each 32-bit and saturating.
  - Grant counters increment on each IDLE→ACCESS for that requester.
  - stat_conflicts increments every cycle in which a requester has req high but is not being served while busy, or loses a tie in IDLE.
  - All counters clear on reset.
- Disabled: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package packages/memory.svh (package memory) holds:
  - typedef enum arb_state_t {IDLE, ACCESS, WAIT, RESP};
  - typedef enum logic {REQ_I, REQ_D} req_id_t;
  - localparam MAX_READ_LAT = 7.
- Sub-module mem_arbiter_stats holds the three saturating counters and is instantiated only under MEM_ARBITER_STATS_EN.
- Arbitration, FSM and the latency counter stay in mem_arbiter.

Test Plan:
- Reset mid-WAIT: i_req at 0x100, drop reset during WAIT → no i_valid, busy=0 and mem_en=0 the next cycle, IDLE.
- Lone fetch at default READ_LAT: i_req at T, i_addr=0x40, mem returns 0x00A00093 → mem_en only at T+1; i_valid at T+3 with i_rdata=0x00A00093.
- Store: d_req, d_we=1, d_addr=0x200, d_wdata=0xDEADBEEF, d_wstrb=0x0F → mem_en/mem_we at T+1, mem_wstrb=0x0F; d_valid at T+2, d_rdata=0.
- Tie after reset: i_req and d_req both high at T → instruction is served first (i_valid T+3); data goes to ACCESS at T+5, d_valid T+7.
- Repeated ties: hold both reqs high, re-raising each on its valid → grants alternate I,D,I,D; no requester waits more than one transaction.
- READ_LAT=4, d_req load 0x300: mem_rdata valid only in ACCESS+4 with 0x1234 → d_valid at T+6, d_rdata=0x1234; changing d_addr during WAIT has no effect.
